// File: rtl/timer_pkg.sv
// Shared definitions for the mm:ss countdown timer control path:
// FSM state encodings, BCD field width and default preset wrap limits.
package timer_pkg;

  localparam int BCD_W = 8;

  localparam logic [BCD_W-1:0] MAX_MIN_DEF = 8'h59;
  localparam logic [BCD_W-1:0] MAX_SEC_DEF = 8'h59;

  typedef enum logic [2:0] {
    ST_SET   = 3'd0,
    ST_IDLE  = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/bcd2_wrap_inc.sv
// Two-digit BCD increment by one, wrapping to 00 once the value reaches MAX.
// Purely combinational; the caller decides when to register the result.
module bcd2_wrap_inc
  import timer_pkg::*;
#(
  parameter logic [BCD_W-1:0] MAX = 8'h59
) (
  input  logic [BCD_W-1:0] val,
  output logic [BCD_W-1:0] inc
);

  // Wrap at MAX, otherwise carry from the ones digit into the tens digit.
  always_comb begin
    inc = val;
    if (val == MAX) begin
      inc = '0;
    end else if (val[3:0] == 4'd9) begin
      inc = {val[7:4] + 4'd1, 4'd0};
    end else begin
      inc = {val[7:4], val[3:0] + 4'd1};
    end
  end

endmodule

// File: rtl/countdown_timer_ctrl.sv
// Control FSM for the mm:ss BCD countdown timer: preset entry, start/stop,
// pause/resume and done/alarm handling. Drives load/dec_en strobes into the
// count datapath and watches its zero flag.
// Optional build macro DONE_BLINK_EN: done_led blinks (toggles per tick) while
// in DONE; without it done_led is held steady during DONE.
module countdown_timer_ctrl
  import timer_pkg::*;
#(
  parameter logic [BCD_W-1:0] MAX_MIN     = MAX_MIN_DEF,
  parameter logic [BCD_W-1:0] MAX_SEC     = MAX_SEC_DEF,
  parameter int unsigned      DONE_HOLD_S = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_1hz,
  input  logic             setting,
  input  logic             min_pulse,
  input  logic             sec_pulse,
  input  logic             stsp_pulse,
  input  logic             pare_pulse,
  input  logic             cnt_zero,
  output logic [BCD_W-1:0] preset_min,
  output logic [BCD_W-1:0] preset_sec,
  output logic             load,
  output logic             dec_en,
  output logic             running,
  output logic             done_led,
  output logic [2:0]       state_o
);

  localparam logic [3:0] HOLD_LAST = 4'(DONE_HOLD_S - 1);

  state_t           state;
  logic [3:0]       hold_cnt;
  logic [BCD_W-1:0] min_inc;
  logic [BCD_W-1:0] sec_inc;

  bcd2_wrap_inc #(.MAX(MAX_MIN)) u_min_inc (.val(preset_min), .inc(min_inc));
  bcd2_wrap_inc #(.MAX(MAX_SEC)) u_sec_inc (.val(preset_sec), .inc(sec_inc));

  assign state_o = state;

  // FSM: state, DONE hold counter and registered strobes / indicators.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      hold_cnt <= '0;
      load     <= 1'b0;
      dec_en   <= 1'b0;
      running  <= 1'b0;
      done_led <= 1'b0;
    end else begin
      load   <= 1'b0;
      dec_en <= 1'b0;
      if (setting) begin
        // Preset entry overrides everything; datapath follows the preset.
        state    <= ST_SET;
        load     <= 1'b1;
        running  <= 1'b0;
        done_led <= 1'b0;
        hold_cnt <= '0;
      end else begin
        case (state)
          ST_SET: begin
            // Final load so the datapath holds the last edited preset.
            state <= ST_IDLE;
            load  <= 1'b1;
          end
          ST_IDLE: begin
            if (stsp_pulse && !cnt_zero) begin
              state   <= ST_RUN;
              running <= 1'b1;
            end
          end
          ST_RUN: begin
            if (stsp_pulse) begin
              state   <= ST_IDLE;
              load    <= 1'b1;
              running <= 1'b0;
            end else if (pare_pulse) begin
              state   <= ST_PAUSE;
              running <= 1'b0;
            end else if (cnt_zero && !dec_en) begin
              // Zero is only trusted once no decrement is still settling;
              // a tick arriving at 00:00 is not turned into a decrement.
              state    <= ST_DONE;
              running  <= 1'b0;
              done_led <= 1'b1;
              hold_cnt <= '0;
            end else if (tick_1hz) begin
              dec_en <= 1'b1;
            end
          end
          ST_PAUSE: begin
            if (stsp_pulse) begin
              state <= ST_IDLE;
              load  <= 1'b1;
            end else if (pare_pulse) begin
              state   <= ST_RUN;
              running <= 1'b1;
            end
          end
          ST_DONE: begin
            if (stsp_pulse || (tick_1hz && hold_cnt == HOLD_LAST)) begin
              state    <= ST_IDLE;
              load     <= 1'b1;
              done_led <= 1'b0;
            end else if (tick_1hz) begin
              hold_cnt <= hold_cnt + 4'd1;
`ifdef DONE_BLINK_EN
              done_led <= ~done_led;
`else
              done_led <= 1'b1;
`endif
            end
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // Preset registers: edited only while already in SET with setting held.
  always_ff @(posedge clk) begin
    if (rst) begin
      preset_min <= '0;
      preset_sec <= '0;
    end else if (state == ST_SET && setting) begin
      if (min_pulse) preset_min <= min_inc;
      if (sec_pulse) preset_sec <= sec_inc;
    end
  end

endmodule
